// File: rtl/hps_pio_sequencer.sv
// Sequences one HPS<->FPGA coprocessor transaction: operand load, datapath run, result readback.
// Optional RUN watchdog is compiled in when SEQ_TIMEOUT_EN is defined.
module hps_pio_sequencer #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned N_OPS       = 16,
   parameter int unsigned N_RES       = 8,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       pio_in,
   output logic [31:0]       pio_out,
   output logic              dp_wr_en,
   output logic [3:0]        dp_wr_addr,
   output logic [DATA_W-1:0] dp_wr_data,
   output logic [1:0]        dp_opcode,
   output logic              dp_start,
   input  logic              dp_done,
   output logic [2:0]        dp_rd_addr,
   input  logic [DATA_W-1:0] dp_rd_data,
   output logic [3:0]        state_dbg
);

   typedef enum logic [3:0] {
      StIdle = 4'b0001,
      StLoad = 4'b0010,
      StRun  = 4'b0100,
      StSend = 4'b1000
   } state_e;

   localparam logic [3:0] OpLast  = 4'(N_OPS - 1);
   localparam logic [2:0] ResLast = 3'(N_RES - 1);

   state_e              state_q, state_d;
   logic [3:0]          sync1_q, sync2_q;
   logic                ack_q, ack_d;
   logic [3:0]          op_cnt_q, op_cnt_d;
   logic                op_full_q, op_full_d;
   logic [2:0]          res_cnt_q, res_cnt_d;
   logic [1:0]          opcode_q, opcode_d;
   logic                wr_en_q, wr_en_d;
   logic [3:0]          wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                start_q;
   logic                req_s, start_s;
   logic [1:0]          op_s;
   logic                accept, complete, cmd, timeout, err, busy;
   logic [7:0]          rd_byte;
   logic                unused_pio;

   assign req_s   = sync2_q[3];
   assign start_s = sync2_q[2];
   assign op_s    = sync2_q[1:0];

   // No word is accepted while the datapath is running.
   assign accept   = req_s & ~ack_q & (state_q != StRun);
   assign complete = ack_q & ~req_s;
   assign cmd      = accept & start_s;

   always_comb begin
      state_d   = state_q;
      ack_d     = ack_q;
      op_cnt_d  = op_cnt_q;
      op_full_d = op_full_q;
      res_cnt_d = res_cnt_q;
      opcode_d  = opcode_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;

      if (accept) begin
         ack_d = 1'b1;
      end else if (complete) begin
         ack_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (cmd) state_d = StLoad;
         end
         StLoad: begin
            if (cmd) begin
               state_d = StLoad;
            end else if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = op_cnt_q;
               wr_data_d = pio_in[DATA_W-1:0];
               if (op_cnt_q == OpLast) begin
                  op_full_d = 1'b1;
               end else begin
                  op_cnt_d = op_cnt_q + 4'd1;
               end
            end else if (complete && op_full_q) begin
               state_d   = StRun;
               op_full_d = 1'b0;
            end
         end
         StRun: begin
            if (dp_done) begin
               state_d   = StSend;
               res_cnt_d = 3'd0;
            end else if (timeout) begin
               state_d = StIdle;
            end
         end
         StSend: begin
            if (cmd) begin
               state_d = StLoad;
            end else if (complete) begin
               if (res_cnt_q == ResLast) begin
                  state_d   = StIdle;
                  res_cnt_d = 3'd0;
               end else begin
                  res_cnt_d = res_cnt_q + 3'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (cmd) begin
         opcode_d  = op_s;
         op_cnt_d  = 4'd0;
         op_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         sync1_q   <= 4'd0;
         sync2_q   <= 4'd0;
         ack_q     <= 1'b0;
         op_cnt_q  <= 4'd0;
         op_full_q <= 1'b0;
         res_cnt_q <= 3'd0;
         opcode_q  <= 2'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= 4'd0;
         wr_data_q <= '0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= pio_in[31:28];
         sync2_q   <= sync1_q;
         ack_q     <= ack_d;
         op_cnt_q  <= op_cnt_d;
         op_full_q <= op_full_d;
         res_cnt_q <= res_cnt_d;
         opcode_q  <= opcode_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         start_q   <= (state_d == StRun) && (state_q != StRun);
      end
   end

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

   logic [WdW-1:0] wd_q, wd_d;
   logic           err_q, err_d;

   assign timeout = (state_q == StRun) && (wd_q == WdLast);

   always_comb begin
      wd_d  = (state_q == StRun) ? wd_q + 1'b1 : '0;
      err_d = err_q;
      if (cmd) begin
         err_d = 1'b0;
      end else if (timeout && !dp_done) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC == 0);
   assign timeout        = 1'b0;
   assign err            = 1'b0;
`endif

   assign unused_pio = ^pio_in[27:8];

   assign busy       = (state_q != StIdle);
   assign rd_byte    = (state_q == StSend) ? dp_rd_data : 8'd0;
   assign pio_out    = {ack_q, busy, err, 21'd0, rd_byte};
   assign dp_wr_en   = wr_en_q;
   assign dp_wr_addr = wr_addr_q;
   assign dp_wr_data = wr_data_q;
   assign dp_opcode  = opcode_q;
   assign dp_start   = start_q;
   assign dp_rd_addr = res_cnt_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_hps_pio_sequencer.sv
// Directed bench for hps_pio_sequencer: HPS handshake tasks plus a simple adder datapath model.
module tb_hps_pio_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pio_in;
   logic [31:0] pio_out;
   logic        dp_wr_en;
   logic [3:0]  dp_wr_addr;
   logic [7:0]  dp_wr_data;
   logic [1:0]  dp_opcode;
   logic        dp_start;
   logic        dp_done;
   logic [2:0]  dp_rd_addr;
   logic [7:0]  dp_rd_data;
   logic [3:0]  state_dbg;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] bank [16];
   int         wr_cnt    = 0;
   int         start_cnt = 0;
   logic [3:0] last_addr = 4'd0;
   logic [7:0] last_data = 8'd0;

   hps_pio_sequencer #(
      .DATA_W      (8),
      .N_OPS       (16),
      .N_RES       (8),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .pio_in     (pio_in),
      .pio_out    (pio_out),
      .dp_wr_en   (dp_wr_en),
      .dp_wr_addr (dp_wr_addr),
      .dp_wr_data (dp_wr_data),
      .dp_opcode  (dp_opcode),
      .dp_start   (dp_start),
      .dp_done    (dp_done),
      .dp_rd_addr (dp_rd_addr),
      .dp_rd_data (dp_rd_data),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   // Adder datapath: result i = operand i + operand i+8.
   assign dp_rd_data = bank[{1'b0, dp_rd_addr}] + bank[{1'b1, dp_rd_addr}];

   always @(posedge clk) begin
      if (dp_wr_en) begin
         bank[dp_wr_addr] <= dp_wr_data;
         wr_cnt           <= wr_cnt + 1;
         last_addr        <= dp_wr_addr;
         last_data        <= dp_wr_data;
      end
      if (dp_start) start_cnt <= start_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input logic lvl, input string tag);
      int n = 0;
      while (pio_out[31] !== lvl && n < 12) begin
         tick;
         n++;
      end
      check(tag, {31'd0, pio_out[31]}, {31'd0, lvl});
   endtask

   task automatic hps_write(input logic st, input logic [1:0] op, input logic [7:0] d);
      pio_in = {1'b1, st, op, 20'd0, d};
      wait_ack(1'b1, "wr_ack_rise");
      pio_in[31] = 1'b0;
      wait_ack(1'b0, "wr_ack_fall");
   endtask

   task automatic hps_read(output logic [7:0] d);
      pio_in = 32'h8000_0000;
      wait_ack(1'b1, "rd_ack_rise");
      d = pio_out[7:0];
      pio_in = 32'h0;
      wait_ack(1'b0, "rd_ack_fall");
   endtask

   logic [7:0] exp_res [8] = '{8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h12, 8'h14, 8'h16, 8'h18};
   logic [7:0] rd;
   int         w0, s0;

   initial begin
      reset_n = 1'b0;
      pio_in  = 32'h0;
      dp_done = 1'b0;
      tick;
      tick;
      check("rst_pio_out", pio_out, 32'h0);
      check("rst_state", {28'd0, state_dbg}, 32'h1);
      check("rst_wr_en", {31'd0, dp_wr_en}, 32'h0);
      check("rst_start", {31'd0, dp_start}, 32'h0);
      check("rst_rd_addr", {29'd0, dp_rd_addr}, 32'h0);
      reset_n = 1'b1;
      tick;

      // Command into LOAD, then a long req pulse for handshake timing.
      hps_write(1'b1, 2'b01, 8'h00);
      check("cmd_state_load", {28'd0, state_dbg}, 32'h2);
      check("cmd_opcode", {30'd0, dp_opcode}, 32'h1);
      check("cmd_pio_busy", pio_out, 32'h4000_0000);
      w0 = wr_cnt;
      pio_in = 32'h8000_0055;
      tick;
      tick;
      check("ack_lat2_low", {31'd0, pio_out[31]}, 32'h0);
      tick;
      check("ack_lat3_high", {31'd0, pio_out[31]}, 32'h1);
      repeat (17) tick;
      check("hold_single_wr", wr_cnt - w0, 32'd1);
      check("hold_wr_addr", {28'd0, last_addr}, 32'h0);
      check("hold_wr_data", {24'd0, last_data}, 32'h55);
      pio_in = 32'h0000_0055;
      tick;
      tick;
      check("ackfall_lat2_high", {31'd0, pio_out[31]}, 32'h1);
      tick;
      check("ackfall_lat3_low", {31'd0, pio_out[31]}, 32'h0);

      // Reset mid-LOAD.
      hps_write(1'b0, 2'b00, 8'h66);
      hps_write(1'b0, 2'b00, 8'h77);
      reset_n = 1'b0;
      tick;
      tick;
      check("midrst_state", {28'd0, state_dbg}, 32'h1);
      check("midrst_pio_out", pio_out, 32'h0);
      check("midrst_opcode", {30'd0, dp_opcode}, 32'h0);
      check("midrst_wr_en", {31'd0, dp_wr_en}, 32'h0);
      reset_n = 1'b1;
      tick;

      // Full transaction with the adder model.
      hps_write(1'b1, 2'b00, 8'h00);
      w0 = wr_cnt;
      s0 = start_cnt;
      for (int i = 0; i < 16; i++) hps_write(1'b0, 2'b00, 8'(i + 1));
      check("full_wr_count", wr_cnt - w0, 32'd16);
      check("full_last_addr", {28'd0, last_addr}, 32'hF);
      check("full_state_run", {28'd0, state_dbg}, 32'h4);
      check("run_busy", {31'd0, pio_out[30]}, 32'h1);
      tick;
      tick;
      check("single_start", start_cnt - s0, 32'd1);
      for (int i = 0; i < 16; i++) check("bank_value", {24'd0, bank[i]}, 32'(i + 1));
      pio_in = 32'h8000_0000;
      repeat (6) tick;
      check("run_no_ack", {31'd0, pio_out[31]}, 32'h0);
      pio_in = 32'h0;
      repeat (4) tick;
      check("run_waits", {28'd0, state_dbg}, 32'h4);
      dp_done = 1'b1;
      tick;
      dp_done = 1'b0;
      check("done_to_send", {28'd0, state_dbg}, 32'h8);
      for (int i = 0; i < 8; i++) begin
         hps_read(rd);
         check("result_byte", {24'd0, rd}, {24'd0, exp_res[i]});
      end
      check("send_to_idle", {28'd0, state_dbg}, 32'h1);
      check("idle_pio_out", pio_out, 32'h0);
      check("start_total", start_cnt - s0, 32'd1);

      // Abort-and-restart by a second command.
      hps_write(1'b1, 2'b10, 8'h00);
      for (int i = 0; i < 5; i++) hps_write(1'b0, 2'b00, 8'(8'h11 + i));
      hps_write(1'b1, 2'b11, 8'h00);
      check("restart_opcode", {30'd0, dp_opcode}, 32'h3);
      hps_write(1'b0, 2'b00, 8'hAA);
      check("restart_addr", {28'd0, last_addr}, 32'h0);
      check("restart_data", {24'd0, last_data}, 32'hAA);
      check("restart_state", {28'd0, state_dbg}, 32'h2);
      for (int i = 1; i < 16; i++) hps_write(1'b0, 2'b00, 8'(i));
      check("restart_run", {28'd0, state_dbg}, 32'h4);

`ifdef SEQ_TIMEOUT_EN
      repeat (15) tick;
      check("wd_cycle16_run", {28'd0, state_dbg}, 32'h4);
      tick;
      check("wd_timeout_idle", {28'd0, state_dbg}, 32'h1);
      check("wd_error_set", pio_out, 32'h2000_0000);
      hps_write(1'b1, 2'b00, 8'h00);
      check("cmd_clears_err", pio_out, 32'h4000_0000);
      for (int i = 0; i < 16; i++) hps_write(1'b0, 2'b00, 8'(i));
      repeat (15) tick;
      dp_done = 1'b1;
      tick;
      dp_done = 1'b0;
      check("done_wins_send", {28'd0, state_dbg}, 32'h8);
      check("done_wins_noerr", {31'd0, pio_out[29]}, 32'h0);
`else
      repeat (1000) tick;
      check("no_wd_still_run", {28'd0, state_dbg}, 32'h4);
      check("no_wd_pio_out", pio_out, 32'h4000_0000);
      dp_done = 1'b1;
      tick;
      dp_done = 1'b0;
      check("late_done_send", {28'd0, state_dbg}, 32'h8);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
